// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch engine sitting between the IF-stage PC
// register and the IF/ID boundary. Issues one instruction-memory request at a
// time, drives the PC enable only when a fetch is issued, and buffers returned
// {pc, instr} pairs in a DEPTH-entry FIFO. Branch redirects flush the queue and
// any in-flight request.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned PCs are not sent to
// memory; a NOP entry tagged with a fault bit is queued instead (id_fault).
module if_fetch_queue #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_value,
    output logic             pc_advance,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             flush,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic             id_fault,
`endif
    input  logic             id_ready,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      pc_store    [DEPTH];
    logic [31:0]      instr_store [DEPTH];

    logic             pop;
    logic             push;
    logic             start_req;
    logic             can_issue;
    logic [CNT_W-1:0] occ_after_pop;
    logic [CNT_W-1:0] occ_after_push;
    logic [31:0]      push_pc;
    logic [31:0]      push_instr;
    logic             pc_aligned;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic             fault_store [DEPTH];
    logic             push_fault;
    assign pc_aligned = (pc_value[1:0] == 2'b00);
`else
    assign pc_aligned = 1'b1;
`endif

    assign id_valid = (occupancy != '0);
    assign id_pc    = id_valid ? pc_store[rd_ptr]    : 32'h0;
    assign id_instr = id_valid ? instr_store[rd_ptr] : 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign id_fault = id_valid ? fault_store[rd_ptr] : 1'b0;
`endif

    // Issue/push decisions: a slot is reserved at issue, so an ack push never overflows
    always_comb begin
        pop            = id_valid && id_ready && !flush;
        occ_after_pop  = occupancy - CNT_W'(pop);
        occ_after_push = occupancy + CNT_W'(1) - CNT_W'(pop);
        can_issue      = !flush && (occ_after_pop < DEPTH_C);
        pc_advance     = 1'b0;
        start_req      = 1'b0;
        push           = 1'b0;
        push_pc        = imem_addr;
        push_instr     = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
        push_fault     = (state == IDLE);
`endif
        case (state)
            IDLE: begin
                if (can_issue) begin
                    pc_advance = 1'b1;
                    if (pc_aligned) begin
                        start_req = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_pc    = pc_value;
                        push_instr = NOP_INSTR;
                    end
                end
            end
            WAIT: begin
                if (imem_ack && !flush) begin
                    push = 1'b1;
                    // A misaligned follow-on PC is left for IDLE to handle next cycle
                    if ((occ_after_push < DEPTH_C) && pc_aligned) begin
                        pc_advance = 1'b1;
                        start_req  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Request FSM: a request, once raised, is held until its ack arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        imem_addr <= pc_value;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (start_req) begin
                            imem_addr <= pc_value;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // FIFO control: pointers wrap naturally at power-of-two depth; flush empties at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage: data only, outputs are masked by id_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            pc_store[wr_ptr]    <= push_pc;
            instr_store[wr_ptr] <= push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_store[wr_ptr] <= push_fault;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized bench for if_fetch_queue. The bench plays the
// PC register and the instruction memory, and keeps a queue-based reference of
// the fetch stream.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      pc_value = 32'h0;
    logic             pc_advance;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_rdata = 32'h0;
    logic             flush = 1'b0;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic             id_ready = 1'b0;
    logic [CNT_W-1:0] occupancy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic             id_fault;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_value   (pc_value),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
        .id_fault   (id_fault),
`endif
        .id_ready   (id_ready),
        .occupancy  (occupancy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: queued entries and the single outstanding request
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    bit          outstanding = 1'b0;
    bit          live = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          age = 0;
    int          lat = 1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          flush_pct = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic model_reset();
        q_pc.delete();
        q_instr.delete();
        outstanding = 1'b0;
        live        = 1'b0;
        age         = 0;
        pc_value    = 32'h0;
    endtask

    // One clock cycle: check outputs, drive memory/ID/flush, check pc_advance, advance model
    task automatic step(input bit mid_reset_en);
        bit push;
        bit pop;
        bit exp_adv;
        logic [31:0] next_pc;
        @(negedge clk);
        chk("imem_req", imem_req, outstanding);
        if (outstanding) chk("imem_addr", imem_addr, out_addr);
        chk("occupancy", occupancy, q_pc.size());
        chk("id_valid", id_valid, q_pc.size() != 0);
        if (q_pc.size() != 0) begin
            chk("id_pc", id_pc, q_pc[0]);
            chk("id_instr", id_instr, q_instr[0]);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("id_fault", id_fault, 0);
`endif
        end
        if (occupancy > DEPTH) chk("occ_bound", occupancy, DEPTH);

        if (imem_req) begin
            age++;
            if (age >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(imem_addr);
                age        = 0;
                lat        = $urandom_range(lat_max, lat_min);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            // Stray acks while nothing is outstanding must be ignored
            age        = 0;
            imem_ack   = ($urandom_range(99, 0) < 10);
            imem_rdata = 32'hdeadbeef;
        end
        id_ready = ($urandom_range(99, 0) < ready_pct);
        flush    = ($urandom_range(99, 0) < flush_pct);
        #1;

        push    = outstanding && live && imem_ack && !flush;
        pop     = (q_pc.size() != 0) && id_ready && !flush;
        exp_adv = !flush && (!outstanding || (imem_ack && live))
                  && ((q_pc.size() - int'(pop) + int'(push)) < DEPTH);
        chk("pc_advance", pc_advance, exp_adv);
        if (flush) chk("flush_adv", pc_advance, 0);

        if (flush)        next_pc = $urandom & 32'h0000_fffc;
        else if (exp_adv) next_pc = pc_value + 32'd4;
        else              next_pc = pc_value;

        if (flush) begin
            q_pc.delete();
            q_instr.delete();
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (push) begin
                q_pc.push_back(out_addr);
                q_instr.push_back(imem_rdata);
            end
        end
        if (exp_adv) begin
            outstanding = 1'b1;
            live        = 1'b1;
            out_addr    = pc_value;
        end else if (outstanding && imem_ack) begin
            outstanding = 1'b0;
        end else if (outstanding && flush) begin
            live = 1'b0;
        end

        @(posedge clk);
        #1;
        pc_value = next_pc;

        // Asynchronous reset between edges while a request is outstanding
        if (mid_reset_en && outstanding && ($urandom_range(19, 0) == 0)) begin
            #1;
            reset    = 1'b1;
            imem_ack = 1'b0;
            flush    = 1'b0;
            #1;
            chk("rst_req", imem_req, 0);
            chk("rst_valid", id_valid, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_id_pc", id_pc, 0);
            model_reset();
            @(posedge clk);
            #2;
            reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", imem_req, 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_valid", id_valid, 0);
        chk("reset_occ", occupancy, 0);
        chk("reset_id_pc", id_pc, 0);
        chk("reset_id_instr", id_instr, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("reset_id_fault", id_fault, 0);
`endif
        model_reset();
        #2;
        reset = 1'b0;

        // Zero-wait memory, ID always ready: one fetch per cycle
        lat_min = 1; lat_max = 1; lat = 1; ready_pct = 100; flush_pct = 0;
        repeat (20) step(0);

        // ID stalled: queue fills to DEPTH and fetching stops
        ready_pct = 0;
        repeat (15) step(0);
        chk("full_occ", occupancy, DEPTH);
        chk("full_req", imem_req, 0);
        chk("full_adv", pc_advance, 0);

        // ID resumes: drain in order and fetching restarts
        ready_pct = 100;
        repeat (10) step(0);

        // Random latency, backpressure and redirects
        lat_min = 1; lat_max = 3; ready_pct = 60; flush_pct = 8;
        repeat (400) step(0);

        // Same traffic with occasional asynchronous reset mid-request
        repeat (300) step(1);

        // Slow memory with frequent redirects exercises the drop path
        lat_min = 3; lat_max = 3; ready_pct = 50; flush_pct = 15;
        repeat (200) step(0);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned PC: no memory request, NOP entry flagged as fault
        #1;
        reset    = 1'b1;
        imem_ack = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        @(posedge clk);
        #2;
        reset    = 1'b0;
        pc_value = 32'h0000_0022;
        @(negedge clk);
        #1;
        chk("mis_adv", pc_advance, 1);
        @(posedge clk);
        #1;
        chk("mis_req", imem_req, 0);
        chk("mis_valid", id_valid, 1);
        chk("mis_id_pc", id_pc, 32'h0000_0022);
        chk("mis_id_instr", id_instr, 32'h0000_0013);
        chk("mis_id_fault", id_fault, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
